// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - ps2_state_t : receive FSM state encoding
//   - READY_BIT / OVF_BIT : bit positions inside the status/data word
//   - START_VAL / STOP_VAL / DATA_BITS : PS/2 device-to-host frame constants
//   - odd_parity_ok() : returns 1 when data plus parity bit carry odd parity
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int   READY_BIT = 8;
  localparam int   OVF_BIT   = 9;
  localparam logic START_VAL = 1'b0;
  localparam logic STOP_VAL  = 1'b1;
  localparam int   DATA_BITS = 8;

  // A PS/2 frame is good when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic parity);
    return (^data) ^ parity;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous FIFO for received scan codes.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push, i_din  write request and data; accepted when not full, or when full together with a pop
//   i_pop          read request; ignored when empty
//   o_head         oldest entry, forced to 0 when empty
//   o_full/o_empty occupancy flags
//   o_count        number of stored entries (log2(DEPTH)+1 bits)
// DEPTH must be a power of two (minimum 2) so the pointers wrap naturally.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A pop in the same clock frees the slot, so a push into a full FIFO is still accepted.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are only visible through o_head when non-empty, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/ps2_kbd_if.sv
// ps2_kbd_if: memory-mapped PS/2 keyboard receiver.
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_ps2_clk    raw PS/2 clock pin (asynchronous)
//   i_ps2_data   raw PS/2 data pin (asynchronous)
//   i_rd         CPU read strobe, pops one scan code
//   o_data_out   {22'b0, overflow, ready, head_code[7:0]}
//   o_frame_err  one-clock pulse on parity, stop-bit or timeout error
// The pins are synchronised, the PS/2 clock is glitch-filtered, and each filtered falling edge
// advances the receive FSM. Good frames land in ps2_fifo two clocks after the stop-bit edge.
module ps2_kbd_if
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  input  logic        i_rd,
  output logic [31:0] o_data_out,
  output logic        o_frame_err
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic                 r_clk_s1;
  logic                 r_clk_s2;
  logic                 r_dat_s1;
  logic                 r_dat_s2;
  logic [FCNT_W-1:0]    r_filt_cnt;
  logic                 r_filt_clk;
  logic                 r_fall;
  ps2_state_t           r_state;
  ps2_state_t           w_next_state;
  logic [DATA_BITS-1:0] r_shreg;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_parity;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 w_timeout;
  logic                 w_push;
  logic                 w_err;
  logic                 r_push;
  logic [DATA_BITS-1:0] r_push_code;
  logic                 r_frame_err;
  logic                 r_ovf;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic [7:0]           w_head;
  logic                 w_ready;
  logic [31:0]          w_data_out;

  // Two-flop synchronisers; the idle bus level is high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock glitch filter: the filtered clock follows only after FILTER_LEN differing samples in a row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt_cnt <= '0;
      r_filt_clk <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
        r_filt_cnt <= '0;
        r_filt_clk <= r_clk_s2;
        // The filtered clock was high, so this change is a falling edge.
        r_fall     <= r_filt_clk;
      end else begin
        r_filt_cnt <= r_filt_cnt + FCNT_W'(1);
      end
    end
  end

  // r_to_cnt holds the number of clocks since the last fall pulse; with the registered error
  // output this places the timeout pulse exactly TIMEOUT_CYC clocks after that fall pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (r_fall) begin
      r_to_cnt <= TO_W'(1);
    end else if (r_state == ST_IDLE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && !r_fall && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Receive FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Receive FSM next-state logic; every step is taken on a fall pulse, timeout overrides.
  always_comb begin
    w_next_state = r_state;
    if (w_timeout) begin
      w_next_state = ST_IDLE;
    end else if (r_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (r_dat_s2 == START_VAL) begin
            w_next_state = ST_DATA;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            w_next_state = ST_PARITY;
          end else begin
            w_next_state = ST_DATA;
          end
        end
        ST_PARITY: w_next_state = ST_STOP;
        ST_STOP:   w_next_state = ST_IDLE;
        default:   w_next_state = ST_IDLE;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // Receive FSM outputs: frame verdict at the stop bit, or abort on timeout.
  always_comb begin
    w_push = 1'b0;
    w_err  = 1'b0;
    if (w_timeout) begin
      w_err = 1'b1;
    end else if (r_fall && (r_state == ST_STOP)) begin
      if ((r_dat_s2 == STOP_VAL) && odd_parity_ok(r_shreg, r_parity)) begin
        w_push = 1'b1;
      end else begin
        w_err = 1'b1;
      end
    end else begin
      w_push = 1'b0;
      w_err  = 1'b0;
    end
  end

  // Frame datapath: LSB-first shift register, bit counter and parity capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (r_fall) begin
      case (r_state)
        ST_IDLE: r_bit_cnt <= '0;
        ST_DATA: begin
          r_shreg   <= {r_dat_s2, r_shreg[DATA_BITS-1:1]};
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
        ST_PARITY: r_parity <= r_dat_s2;
        default:   r_parity <= r_parity;
      endcase
    end
  end

  // Registered push request, captured code and error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_push      <= 1'b0;
      r_push_code <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= w_push;
      r_frame_err <= w_err;
      if (w_push) begin
        r_push_code <= r_shreg;
      end
    end
  end

  assign w_pop = i_rd & ~w_empty;

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_din   (r_push_code),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sticky overflow: set on a dropped push, cleared by any read strobe; set wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (r_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (i_rd) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign w_ready = (w_count != '0);

  // Status/data word assembly.
  always_comb begin
    w_data_out            = '0;
    w_data_out[7:0]       = w_head;
    w_data_out[READY_BIT] = w_ready;
    w_data_out[OVF_BIT]   = r_ovf;
  end

  assign o_data_out  = w_data_out;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_if.sv
// Self-checking bench for ps2_kbd_if. A queue-based model of the scan-code buffer predicts the
// status/data word; PS/2 frames are bit-banged with a slow clock (8 clk high, 8 clk low).
module tb_ps2_kbd_if;

  localparam int DEPTH = 8;
  localparam int FLEN  = 4;
  localparam int TCYC  = 200;
  localparam int HI    = 8;
  localparam int LO    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic        rd;
  logic [31:0] data_out;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  ps2_kbd_if #(
    .FIFO_DEPTH  (DEPTH),
    .FILTER_LEN  (FLEN),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .i_rd        (rd),
    .o_data_out  (data_out),
    .o_frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Expected status word from the model: {ovf, ready, head}.
  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    w = 32'h0;
    if (mq.size() > 0) begin
      w[7:0] = mq[0];
      w[8]   = 1'b1;
    end
    w[9] = m_ovf;
    return w;
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stp);
    if (stp && ((^d) ^ par)) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_read();
    if (mq.size() > 0) void'(mq.pop_front());
    m_ovf = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      cycles(4);
      ps2_clk = 1'b0;
      cycles(FLEN - 1);
      ps2_clk = 1'b1;
      cycles(8);
    end
    cycles(HI);
    ps2_clk = 1'b0;
    cycles(LO);
    ps2_clk = 1'b1;
  endtask

  // Start bit, eight data bits LSB first, parity bit.
  task automatic send_head(input logic [7:0] d, input logic par, input int glitch_at);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch_at == i);
    send_bit(par, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int glitch_at);
    send_head(d, par, glitch_at);
    send_bit(stp, 1'b0);
    ps2_data = 1'b1;
    model_frame(d, par, stp);
    cycles(4);
  endtask

  task automatic do_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    model_read();
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
    cycles(3);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", data_out, 32'h0); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    rst = 1'b0;
    cycles(10);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_release: got %h expected %h", data_out, 32'h0); end
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_pulses;
    send_head(8'h1C, 1'b0, -1);
    ps2_data = 1'b1;
    cycles(HI);
    ps2_clk = 1'b0;
    cycles(7);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL basic_early: got %h expected %h", data_out, 32'h0); end
    cycles(1);
    checks++;
    if (data_out !== 32'h0000_011C) begin errors++; $display("FAIL basic_ready: got %h expected %h", data_out, 32'h0000_011C); end
    ps2_clk = 1'b1;
    model_frame(8'h1C, 1'b0, 1'b1);
    cycles(4);
    checks++;
    if (err_pulses != e0) begin errors++; $display("FAIL basic_noerr: got %0d pulses expected 0", err_pulses - e0); end
    do_read();
    checks++;
    if (data_out !== exp_word()) begin errors++; $display("FAIL basic_read: got %h expected %h", data_out, exp_word()); end
  endtask

  task automatic test_parity_err();
    int e0;
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    checks++;
    if (err_pulses - e0 != 1) begin errors++; $display("FAIL parity_pulse: got %0d pulses expected 1", err_pulses - e0); end
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL parity_data: got %h expected %h", data_out, 32'h0); end
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    checks++;
    if (data_out !== exp_word()) begin errors++; $display("FAIL parity_next: got %h expected %h", data_out, exp_word()); end
    do_read();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), good_par(8'(i)), 1'b1, -1);
    checks++;
    if (data_out !== 32'h0000_0301) begin errors++; $display("FAIL ovf_word: got %h expected %h", data_out, 32'h0000_0301); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (data_out[7:0] !== 8'(i)) begin errors++; $display("FAIL ovf_order: got %h expected %h", data_out[7:0], 8'(i)); end
      do_read();
      checks++;
      if (data_out !== exp_word()) begin errors++; $display("FAIL ovf_after_rd%0d: got %h expected %h", i, data_out, exp_word()); end
    end
    checks++;
    if (data_out[8] !== 1'b0) begin errors++; $display("FAIL ovf_empty: got ready=%b expected 0", data_out[8]); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      send_frame(d, good_par(d), 1'b1, -1);
    end
    d = 8'($urandom);
    send_head(d, good_par(d), -1);
    ps2_data = 1'b1;
    cycles(HI);
    ps2_clk = 1'b0;
    cycles(7);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    model_read();
    model_frame(d, good_par(d), 1'b1);
    ps2_clk = 1'b1;
    cycles(4);
    checks++;
    if (data_out !== exp_word()) begin errors++; $display("FAIL fullpp_word: got %h expected %h", data_out, exp_word()); end
    while (mq.size() > 0) begin
      do_read();
      checks++;
      if (data_out !== exp_word()) begin errors++; $display("FAIL fullpp_drain: got %h expected %h", data_out, exp_word()); end
    end
    do_read();
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL fullpp_rd_empty: got %h expected %h", data_out, 32'h0); end
  endtask

  task automatic test_timeout();
    int first_k;
    int pulses;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    ps2_data = 1'($urandom);
    cycles(HI);
    ps2_clk = 1'b0;
    first_k = -1;
    pulses = 0;
    for (int k = 1; k <= TCYC + 20; k++) begin
      @(negedge clk);
      if (k == LO) ps2_clk = 1'b1;
      if (frame_err === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    ps2_data = 1'b1;
    checks++;
    if (first_k != 6 + TCYC) begin errors++; $display("FAIL timeout_time: got %0d expected %0d", first_k, 6 + TCYC); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", pulses); end
    send_frame(8'h5A, good_par(8'h5A), 1'b1, -1);
    checks++;
    if (data_out !== 32'h0000_015A) begin errors++; $display("FAIL timeout_next: got %h expected %h", data_out, 32'h0000_015A); end
    do_read();
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    d = 8'($urandom);
    send_frame(d, good_par(d), 1'b1, int'($urandom_range(1, 7)));
    checks++;
    if (data_out !== exp_word()) begin errors++; $display("FAIL glitch_word: got %h expected %h", data_out, exp_word()); end
    do_read();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] old;
    old = 8'h29;
    send_frame(8'h11, good_par(8'h11), 1'b1, -1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(old[i], 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected %h", data_out, 32'h0); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", frame_err); end
    mq.delete();
    m_ovf = 1'b0;
    cycles(2);
    rst = 1'b0;
    for (int i = 4; i < 8; i++) send_bit(old[i], 1'b0);
    send_bit(good_par(old), 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    cycles(TCYC + 20);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL rstmid_nopush: got %h expected %h", data_out, 32'h0); end
    send_frame(8'h29, good_par(8'h29), 1'b1, -1);
    checks++;
    if (data_out !== 32'h0000_0129) begin errors++; $display("FAIL rstmid_next: got %h expected %h", data_out, 32'h0000_0129); end
    do_read();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       par;
    logic       stp;
    int         kind;
    int         e0;
    int         exp_e;
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      par  = (kind == 0) ? ~good_par(d) : good_par(d);
      stp  = (kind == 1) ? 1'b0 : 1'b1;
      exp_e = (kind <= 1) ? 1 : 0;
      e0   = err_pulses;
      send_frame(d, par, stp, -1);
      checks++;
      if (err_pulses - e0 != exp_e) begin errors++; $display("FAIL rand_err%0d: got %0d expected %0d", n, err_pulses - e0, exp_e); end
      checks++;
      if (data_out !== exp_word()) begin errors++; $display("FAIL rand_word%0d: got %h expected %h", n, data_out, exp_word()); end
      for (int r = 0; r < int'($urandom_range(0, 2)); r++) begin
        do_read();
        checks++;
        if (data_out !== exp_word()) begin errors++; $display("FAIL rand_read%0d: got %h expected %h", n, data_out, exp_word()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_if.md
Name: ps2_kbd_if

Overview:
- Memory-mapped PS/2 keyboard receiver that sits upstream of the CPU keyboard polling loop at base address 0xA000_0000.
- Deserialises PS/2 device-to-host frames and buffers the scan codes in a small FIFO.
- Presents a status/data word: bit 8 = ready, bits 7:0 = scan code.
- A CPU read strobe pops one entry, so software polls bit 8 and then consumes bits 7:0.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; must be a power of 2, minimum 2.
- FILTER_LEN, 4, consecutive equal samples needed before the filtered ps2_clk changes.
- TIMEOUT_CYC, 50000, clk cycles without a falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- rd  in  1  CPU read strobe; high for one clk when a load decodes to the keyboard address.
- data_out  out  32  {22'b0, overflow, ready, head_code[7:0]}.
- frame_err  out  1  one-clk pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset values: data_out=0, frame_err=0, FIFO empty, overflow=0, FSM=IDLE, filter counter=0, filtered clock=1.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flip-flops.
  - Filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples.
  - A falling edge is filtered 1→0 and produces a one-clk fall pulse.
  - Data is sampled (synchronised) on the fall pulse.
- FSM states and transitions, each step taken on a fall pulse:
  - IDLE: sample 0 → DATA with bit_cnt=0; sample 1 → stay in IDLE (no error).
  - DATA: shift right into shreg (LSB first); after 8 bits → PARITY.
  - PARITY: store sampled bit → STOP.
  - STOP: if stop=1 and (^shreg ^ parity)==1 (odd parity), push shreg; otherwise pulse frame_err. Always return to IDLE.
- Timeout: a counter clears on every fall pulse and runs in every state except IDLE.
  - When it reaches TIMEOUT_CYC: FSM → IDLE, frame_err pulses, and the partial byte is discarded.
- FIFO:
  - Push occurs in the clk after the stop-bit sample. ready=1 in the following clk, i.e. 2 clks after the fall pulse.
  - data_out[7:0] shows the head entry combinationally and is 0 when empty.
  - Pop: rd=1 and not empty → head advances at the clk edge.
  - rd on empty FIFO: no effect.
  - Simultaneous push and pop when full: both occur, count is unchanged, no overflow.
  - Push when full without pop: code dropped, overflow set.
- overflow: sticky; cleared on any clk where rd=1, with set having priority over clear in the same clk.
- Pointers are log2(FIFO_DEPTH) bits with natural wrap. Count is log2(FIFO_DEPTH)+1 bits.
- Host-to-device transmit is not supported; the pins are input-only.
- Reset mid-frame: FSM → IDLE immediately. Remaining edges of that frame are ignored until the next frame starts with a 0 sampled in IDLE. A resulting non-0xxx framing error simply pulses frame_err.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding: IDLE, DATA, PARITY, STOP.
  - Status bit positions: READY_BIT=8, OVF_BIT=9.
  - Frame constants: START_VAL=0, STOP_VAL=1, DATA_BITS=8.
- Sub-module ps2_fifo: parameterised synchronous FIFO with push, pop, full, empty, head and count. The receive FSM, edge filter and timeout live in the top.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) → ready=1 and data_out=0x0000_011C 2 clks after the stop fall pulse; one rd → data_out=0.
- Frame 0x1C with parity=1 → frame_err pulses once, data_out stays 0; the next good frame 0xF0 (parity 1) → data_out=0x0000_01F0.
- 9 good frames 0x01..0x09 with no reads → data_out=0x0000_0301. Eight reads return 0x01..0x08 in order, the first rd clears overflow, and ready=0 after the 8th; 0x09 is lost.
- Start bit plus 5 data bits, then idle → frame_err pulses exactly TIMEOUT_CYC clks after the last fall pulse; a following frame 0x5A is received correctly.
- Glitch on ps2_clk low for FILTER_LEN-1 clks mid-frame → no bit consumed; the frame completes with the correct code.
- rst asserted after 4 data bits → outputs 0 immediately. After release, the rest of the old frame produces no push, and the next full frame 0x29 → data_out=0x0000_0129.
